// File: rtl/lcd_text_refresh.sv
// HD44780-style text LCD refresher: runs power-up/init once, then endlessly rescans
// a 2x16 character shadow buffer to the panel in 8-bit write-only mode.
module lcd_text_refresh #(
  parameter int PHASE_CYC = 4,
  parameter int CMD_WAIT  = 40,
  parameter int CLR_WAIT  = 1600,
  parameter int PWR_WAIT  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  localparam int MAX_A = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
  localparam int MAX_B = (CMD_WAIT > PHASE_CYC) ? CMD_WAIT : PHASE_CYC;
  localparam int MAX_V = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_V + 1);

  typedef enum logic [2:0] {S_PWR, S_INIT, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2} main_t;
  typedef enum logic [1:0] {B_SETUP, B_EHI, B_HOLD, B_WAIT} bus_t;

  main_t              state, state_nx;
  bus_t               bus, bus_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, wait_last;
  logic [3:0]         idx, idx_nx;
  logic               start, frame_nx, rs_nx;
  logic [7:0]         byte_nx;
  logic [7:0]         text_mem [32];

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  assign lcd_rw = 1'b0;

  always_comb begin
    state_nx  = state;
    bus_nx    = bus;
    cnt_nx    = cnt + CNT_W'(1);
    idx_nx    = idx;
    start     = 1'b0;
    frame_nx  = 1'b0;
    // Only the clear-display command needs the long settle time.
    wait_last = (state == S_INIT && idx == 4'd3) ? CNT_W'(CLR_WAIT - 1) : CNT_W'(CMD_WAIT - 1);
    if (state == S_PWR) begin
      if (cnt == CNT_W'(PWR_WAIT)) begin
        state_nx = S_INIT;
        idx_nx   = 4'd0;
        start    = 1'b1;
      end
    end else begin
      case (bus)
        B_SETUP: if (cnt == CNT_W'(PHASE_CYC - 1)) begin bus_nx = B_EHI;  cnt_nx = '0; end
        B_EHI:   if (cnt == CNT_W'(PHASE_CYC - 1)) begin bus_nx = B_HOLD; cnt_nx = '0; end
        B_HOLD:  if (cnt == CNT_W'(PHASE_CYC - 1)) begin bus_nx = B_WAIT; cnt_nx = '0; end
        default: if (cnt == wait_last) begin
          start = 1'b1;
          case (state)
            S_INIT:  if (idx == 4'd3) begin state_nx = S_ADDR1; idx_nx = 4'd0; end
                     else idx_nx = idx + 4'd1;
            S_ADDR1: begin state_nx = S_LINE1; idx_nx = 4'd0; end
            S_LINE1: if (idx == 4'd15) begin state_nx = S_ADDR2; idx_nx = 4'd0; end
                     else idx_nx = idx + 4'd1;
            S_ADDR2: begin state_nx = S_LINE2; idx_nx = 4'd0; end
            default: if (idx == 4'd15) begin
                       state_nx = S_ADDR1;
                       idx_nx   = 4'd0;
                       frame_nx = 1'b1;
                     end else idx_nx = idx + 4'd1;
          endcase
        end
      endcase
    end
    if (start) begin
      bus_nx = B_SETUP;
      cnt_nx = '0;
    end
  end

  // Byte for the transaction about to enter SETUP; buffer read sees pre-write contents.
  always_comb begin
    rs_nx   = 1'b1;
    byte_nx = 8'h20;
    case (state_nx)
      S_INIT:  begin rs_nx = 1'b0; byte_nx = init_cmd(idx_nx[1:0]); end
      S_ADDR1: begin rs_nx = 1'b0; byte_nx = 8'h80; end
      S_LINE1: byte_nx = text_mem[{1'b0, idx_nx}];
      S_ADDR2: begin rs_nx = 1'b0; byte_nx = 8'hC0; end
      S_LINE2: byte_nx = text_mem[{1'b1, idx_nx}];
      default: begin rs_nx = 1'b0; byte_nx = 8'h00; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_PWR;
      bus        <= B_SETUP;
      cnt        <= '0;
      idx        <= '0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 32; i++) text_mem[i] <= 8'h20;
    end else begin
      state      <= state_nx;
      bus        <= bus_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      lcd_e      <= (state_nx != S_PWR) && (bus_nx == B_EHI);
      frame_done <= frame_nx;
      if (start) begin
        lcd_rs   <= rs_nx;
        lcd_data <= byte_nx;
      end
      if (start && state_nx == S_ADDR1) init_done <= 1'b1;
      if (wr_en) text_mem[wr_addr] <= wr_data;
    end
  end

endmodule
